// File: rtl/batchnorm_stats_accum_if.sv
// Handshake bundle between the batch-statistics producer and its neighbours.
// The slave side is the statistics block. The master side feeds it samples
// and consumes its results.
interface batchnorm_stats_accum_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             x_valid;
  logic             x_ready;
  logic [WIDTH-1:0] x_in;
  logic             stats_valid;
  logic             stats_ready;
  logic [WIDTH-1:0] mean_out;
  logic [WIDTH-1:0] var_out;
  logic             busy;

  modport master (
    output start, x_valid, x_in, stats_ready,
    input  x_ready, stats_valid, mean_out, var_out, busy
  );

  modport slave (
    input  start, x_valid, x_in, stats_ready,
    output x_ready, stats_valid, mean_out, var_out, busy
  );
endinterface

// File: rtl/batchnorm_stats_accum.sv
// Streaming batch mean / biased variance over N = 2^LOG2N signed Q-format
// samples. All scaling by N is done with arithmetic shifts. The variance is
// E[x^2] - mean^2, clamped to the non-negative signed range of WIDTH.
module batchnorm_stats_accum #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LOG2N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  batchnorm_stats_accum_if.slave   bus
);
  localparam int SW = WIDTH + LOG2N;      // sum width
  localparam int PW = 2 * WIDTH;          // full square width
  localparam int QW = 2 * WIDTH + LOG2N;  // sum-of-squares width
  localparam int VW = QW + 1;             // variance difference width

  localparam logic [LOG2N-1:0]     LAST = '1;  // count value of sample N
  localparam logic signed [VW-1:0] VMAX = VW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] FIN1  = 3'd2;
  localparam logic [2:0] FIN2  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]              state_reg, state_next;
  logic signed [SW-1:0]    sum_reg;
  logic signed [QW-1:0]    sumsq_reg;
  logic [LOG2N-1:0]        count_reg;
  logic signed [WIDTH-1:0] mean_w_reg;
  logic signed [QW-1:0]    esq_w_reg;
  logic [WIDTH-1:0]        mean_out_reg;
  logic [WIDTH-1:0]        var_out_reg;

  logic signed [WIDTH-1:0] x_s;
  logic signed [PW-1:0]    sq;
  logic signed [PW-1:0]    msq;
  logic signed [VW-1:0]    var_w;
  logic [WIDTH-1:0]        var_sat;
  logic                    xfer;

  assign x_s   = $signed(bus.x_in);
  assign sq    = PW'(x_s) * PW'(x_s);
  assign msq   = (PW'(mean_w_reg) * PW'(mean_w_reg)) >>> FRAC;
  assign var_w = VW'(esq_w_reg) - VW'(msq);
  assign xfer  = (state_reg == ACCUM) && bus.x_valid;

  // Clamp the variance: negative values are rounding artefacts of the floor shifts.
  always_comb begin
    var_sat = var_w[WIDTH-1:0];
    if (var_w[VW-1])
      var_sat = '0;
    else if (var_w > VMAX)
      var_sat = VMAX[WIDTH-1:0];
  end

  // Batch sequencing: accumulate N samples, two finish stages, then hold results.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = ACCUM;
      ACCUM:   if (xfer && count_reg == LAST) state_next = FIN1;
      FIN1:    state_next = FIN2;
      FIN2:    state_next = DONE;
      DONE:    if (bus.stats_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, accumulators and the two-stage finishing pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sum_reg      <= '0;
      sumsq_reg    <= '0;
      count_reg    <= '0;
      mean_w_reg   <= '0;
      esq_w_reg    <= '0;
      mean_out_reg <= '0;
      var_out_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && bus.start) begin
        sum_reg   <= '0;
        sumsq_reg <= '0;
        count_reg <= '0;
      end else if (xfer) begin
        sum_reg   <= sum_reg + SW'(x_s);
        sumsq_reg <= sumsq_reg + QW'(sq);
        count_reg <= count_reg + LOG2N'(1);
      end
      if (state_reg == FIN1) begin
        mean_w_reg <= WIDTH'(sum_reg >>> LOG2N);
        esq_w_reg  <= sumsq_reg >>> (LOG2N + FRAC);
      end
      if (state_reg == FIN2) begin
        mean_out_reg <= mean_w_reg;
        var_out_reg  <= var_sat;
      end
    end
  end

  assign bus.x_ready     = (state_reg == ACCUM);
  assign bus.stats_valid = (state_reg == DONE);
  assign bus.busy        = (state_reg != IDLE);
  assign bus.mean_out    = mean_out_reg;
  assign bus.var_out     = var_out_reg;
endmodule

// File: tb/tb_batchnorm_stats_accum.sv
// Directed bench for batchnorm_stats_accum with N=4. Stimulus pushes the
// hand-computed {mean, var} of each batch into a queue; a monitor pops and
// compares whenever a stats handshake completes.
module tb_batchnorm_stats_accum;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  batchnorm_stats_accum_if #(.WIDTH(16)) bus ();

  batchnorm_stats_accum #(
    .WIDTH(16),
    .FRAC (8),
    .LOG2N(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: sample mid-cycle, compare when the stats handshake will complete.
  always @(negedge clk) begin
    if (!rst && bus.stats_valid && bus.stats_ready) begin
      txn++;
      if (exp_q.size() == 0) begin
        check("unexpected_stats", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("stats txn %0d: mean=0x%04h var=0x%04h expected mean=0x%04h var=0x%04h",
                 txn, bus.mean_out, bus.var_out, e[31:16], e[15:0]);
        check("sb_mean", {16'd0, bus.mean_out}, {16'd0, e[31:16]});
        check("sb_var",  {16'd0, bus.var_out},  {16'd0, e[15:0]});
      end
    end
  end

  // Offer one sample and wait (bounded) until it is accepted. Enters/leaves at posedge+1.
  task automatic send(input logic [15:0] x, input bit gaps);
    int t;
    if (gaps) begin
      bus.x_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    bus.x_valid = 1'b1;
    bus.x_in    = x;
    t = 0;
    @(negedge clk);
    while (!bus.x_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.x_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
  endtask

  task automatic run_batch(input logic [15:0] s0, s1, s2, s3,
                           input logic [15:0] em, ev, input bit stall);
    logic [15:0] smp [4];
    smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
    exp_q.push_back({em, ev});
    bus.stats_ready = !stall;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 4; i++) send(smp[i], stall);
    // Now just after edge k (the 4th accept).
    check("lat_k_valid",  {31'd0, bus.stats_valid}, 32'd0);
    check("lat_k_xready", {31'd0, bus.x_ready},     32'd0);
    @(posedge clk); #1;
    check("lat_k1_valid", {31'd0, bus.stats_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_k2_valid", {31'd0, bus.stats_valid}, 32'd1);
    if (stall) begin
      for (int c = 0; c < 5; c++) begin
        bus.start = (c == 2);
        @(posedge clk); #1;
        check("stall_valid", {31'd0, bus.stats_valid}, 32'd1);
        check("stall_mean",  {16'd0, bus.mean_out},    {16'd0, em});
        check("stall_var",   {16'd0, bus.var_out},     {16'd0, ev});
      end
      bus.start = 1'b0;
      bus.stats_ready = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    check("idle_valid", {31'd0, bus.stats_valid}, 32'd0);
    check("idle_busy",  {31'd0, bus.busy},        32'd0);
    check("idle_mean_held", {16'd0, bus.mean_out}, {16'd0, em});
    check("idle_var_held",  {16'd0, bus.var_out},  {16'd0, ev});
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_in = '0;
    bus.stats_ready = 1'b1;
    #3;
    check("rst_valid",  {31'd0, bus.stats_valid}, 32'd0);
    check("rst_xready", {31'd0, bus.x_ready},     32'd0);
    check("rst_busy",   {31'd0, bus.busy},        32'd0);
    check("rst_mean",   {16'd0, bus.mean_out},    32'd0);
    check("rst_var",    {16'd0, bus.var_out},     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: ramp
    run_batch(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0140, 1'b0);

    // A sample offered in IDLE must not be consumed.
    bus.x_valid = 1'b1;
    bus.x_in = 16'h7000;
    @(posedge clk); #1;
    check("idle_no_xready", {31'd0, bus.x_ready}, 32'd0);
    bus.x_valid = 1'b0;

    // 2: constant
    run_batch(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b0);
    // 3: symmetric
    run_batch(16'hFF00, 16'hFF00, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 1'b0);
    // 4: saturated variance
    run_batch(16'h7F00, 16'h8100, 16'h7F00, 16'h8100, 16'h0000, 16'h7FFF, 1'b0);
    // 5: x_valid gaps and a stalled DONE with an ignored start
    run_batch(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0140, 1'b1);

    // 6: reset in the middle of a batch
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid",  {31'd0, bus.stats_valid}, 32'd0);
    check("midrst_xready", {31'd0, bus.x_ready},     32'd0);
    check("midrst_busy",   {31'd0, bus.busy},        32'd0);
    check("midrst_mean",   {16'd0, bus.mean_out},    32'd0);
    check("midrst_var",    {16'd0, bus.var_out},     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_batch(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0140, 1'b0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("txn_count", txn, 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
